// File: rtl/spi_slave_ctrlr.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrlr
//  SPI responder. The clock, select and data pins are oversampled in the clk
//  domain through synchronisers. All four cpol/cpha modes are supported, and
//  words are shifted MSB first. Received words appear on dout with a one-cycle
//  done pulse. Transmit words come from a one-deep buffer that is filled
//  through a valid/ready handshake.
//
//  Ports
//   clk, rst       system clock (posedge), asynchronous active-low reset
//   cpol, cpha     SPI mode; latched when the responder is selected
//   sclk, ss_n     SPI clock and active-low select from the master (async)
//   mosi           serial data in (async)
//   miso, miso_oe  serial data out and pad output enable
//   din, tx_valid  transmit word and its valid strobe
//   tx_ready       TX buffer empty
//   dout, done     last received word and its completion pulse
//   tx_underrun    pulse: a word load found the TX buffer empty
//   ready          responder idle (not selected)
// ---------------------------------------------------------------------------
module spi_slave_ctrlr #(
  parameter int D_BITS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [D_BITS-1:0] din,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [D_BITS-1:0] dout,
  output logic              done,
  output logic              tx_underrun,
  output logic              ready
);

  localparam int CNT_W = (D_BITS > 2) ? $clog2(D_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(D_BITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Registered state (_q) and next state (_d)
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q,   ss_prev_d;
  state_e                 state_q,     state_d;
  logic                   cpol_q,      cpol_d;
  logic                   cpha_q,      cpha_d;
  logic [D_BITS-1:0]      tx_sh_q,     tx_sh_d;
  logic [D_BITS-1:0]      rx_sh_q,     rx_sh_d;
  logic [D_BITS-1:0]      dout_q,      dout_d;
  logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
  logic                   primed_q,    primed_d;
  logic                   pend_q,      pend_d;
  logic [D_BITS-1:0]      buf_q,       buf_d;
  logic                   buf_full_q,  buf_full_d;
  logic                   miso_q,      miso_d;
  logic                   miso_oe_q,   miso_oe_d;
  logic                   tx_ready_q,  tx_ready_d;
  logic                   done_q,      done_d;
  logic                   undr_q,      undr_d;
  logic                   ready_q,     ready_d;

  // Combinational helpers
  logic sclk_s, ss_s, mosi_s;
  logic rise_s, fall_s, lead_s, trail_s, sample_s, shift_s;
  logic ss_fall_s, ss_rise_s, load_s;

  // Synchronised pin values and edge decode from the latched mode
  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    ss_s      = ss_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    rise_s    = sclk_s & ~sclk_prev_q;
    fall_s    = ~sclk_s & sclk_prev_q;
    lead_s    = cpol_q ? fall_s : rise_s;
    trail_s   = cpol_q ? rise_s : fall_s;
    sample_s  = cpha_q ? trail_s : lead_s;
    shift_s   = cpha_q ? lead_s : trail_s;
    ss_fall_s = ss_prev_q & ~ss_s;
    ss_rise_s = ~ss_prev_q & ss_s;
  end

  // Next-state computation for the FSM, shifters and TX buffer
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    dout_d      = dout_q;
    bit_cnt_d   = bit_cnt_q;
    primed_d    = primed_q;
    pend_d      = pend_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    done_d      = 1'b0;
    undr_d      = 1'b0;
    load_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          cpol_d    = cpol;
          cpha_d    = cpha;
          bit_cnt_d = '0;
          primed_d  = 1'b0;
          pend_d    = 1'b0;
          load_s    = 1'b1;
          state_d   = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_s) begin
          // Deselect drops the partial word; the TX buffer is untouched.
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
        end else begin
          if (sample_s) begin
            rx_sh_d = {rx_sh_q[D_BITS-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              dout_d    = {rx_sh_q[D_BITS-2:0], mosi_s};
              done_d    = 1'b1;
              bit_cnt_d = '0;
              pend_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            rx_sh_d = rx_sh_q;
          end
          if (shift_s) begin
            if (pend_q) begin
              load_s = 1'b1;
              pend_d = 1'b0;
            end else if (cpha_q && !primed_q) begin
              // First leading edge in cpha=1: MSB is already on miso.
              primed_d = 1'b1;
            end else begin
              tx_sh_d = {tx_sh_q[D_BITS-2:0], 1'b0};
            end
          end else begin
            primed_d = primed_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A load takes the old buffer contents even if din is accepted this cycle.
    if (load_s) begin
      buf_full_d = 1'b0;
      if (buf_full_q) begin
        tx_sh_d = buf_q;
      end else begin
        tx_sh_d = '0;
        undr_d  = 1'b1;
      end
    end else begin
      undr_d = 1'b0;
    end

    if (tx_valid && tx_ready_q) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end else begin
      buf_d = buf_d;
    end

    // Outputs are registered from next state so they track the state exactly.
    miso_d     = (state_d == ST_ACTIVE) ? tx_sh_d[D_BITS-1] : 1'b0;
    miso_oe_d  = (state_d == ST_ACTIVE);
    ready_d    = (state_d == ST_IDLE);
    tx_ready_d = ~buf_full_d;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      dout_q      <= '0;
      bit_cnt_q   <= '0;
      primed_q    <= 1'b0;
      pend_q      <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      undr_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      dout_q      <= dout_d;
      bit_cnt_q   <= bit_cnt_d;
      primed_q    <= primed_d;
      pend_q      <= pend_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      tx_ready_q  <= tx_ready_d;
      done_q      <= done_d;
      undr_q      <= undr_d;
      ready_q     <= ready_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign dout        = dout_q;
  assign done        = done_q;
  assign tx_underrun = undr_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_spi_slave_ctrlr.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_ctrlr
//  Directed bench for spi_slave_ctrlr: a behavioural SPI master drives the
//  pins with a half-period of HP clk cycles, and each scenario task checks
//  the received word, the miso stream and the pulse counts against
//  hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_slave_ctrlr;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, done, tx_underrun, ready;
  logic [7:0] din = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] dout;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int undr_cnt = 0;
  logic [7:0] dout_log [0:7];

  spi_slave_ctrlr #(.D_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .din(din), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dout(dout), .done(done), .tx_underrun(tx_underrun),
    .ready(ready)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts done/tx_underrun pulses and logs dout per done.
  always @(posedge clk) begin
    if (done) begin
      dout_log[done_cnt % 8] <= dout;
      done_cnt <= done_cnt + 1;
    end
    if (tx_underrun) undr_cnt <= undr_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] v);
    int t;
    t = 0;
    while (!tx_ready && t < 50) begin
      wait_clks(1);
      t++;
    end
    if (!tx_ready) begin
      n_cmp++; n_err++;
      $display("FAIL write_tx_timeout: tx_ready=%b required 1", tx_ready);
    end
    din = v;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
  endtask

  task automatic begin_sel(input logic c_pol, input logic c_pha);
    cpol = c_pol;
    cpha = c_pha;
    sclk = c_pol;
    wait_clks(HP);
    ss_n = 1'b0;
    wait_clks(HP);
  endtask

  task automatic end_sel();
    wait_clks(HP);
    ss_n = 1'b1;
    wait_clks(HP);
  endtask

  // Shift nbits of tx out on mosi, collecting miso at each sample edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, input logic c_pol,
                      input logic c_pha, input bit wr_en, input logic [7:0] wr_val,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!c_pha) begin
        mosi = tx[7-i];
        wait_clks(HP);
        sclk = ~c_pol;
        rx = {rx[6:0], miso};
        wait_clks(HP);
        sclk = c_pol;
      end else begin
        wait_clks(HP);
        sclk = ~c_pol;
        mosi = tx[7-i];
        wait_clks(HP);
        sclk = c_pol;
        rx = {rx[6:0], miso};
      end
      if (wr_en && i == 3) write_tx(wr_val);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({miso, miso_oe, done, tx_underrun} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s_pulses: miso/oe/done/undr=%b required 0000", tag,
               {miso, miso_oe, done, tx_underrun});
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_tx_ready: got %b required 1", tag, tx_ready);
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL %s_ready: got %b required 1", tag, ready);
    end
    n_cmp++;
    if (dout !== 8'h00) begin
      n_err++; $display("FAIL %s_dout: got %h required 00", tag, dout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_clks(3);
    check_idle_outputs("reset");
    rst = 1'b1;
    wait_clks(6);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_modes();
    logic [7:0] m;
    int base;
    for (int md = 0; md < 4; md++) begin
      base = done_cnt;
      write_tx(8'hA5);
      n_cmp++;
      if (tx_ready !== 1'b0) begin
        n_err++; $display("FAIL mode%0d_buf_full: tx_ready=%b required 0", md, tx_ready);
      end
      begin_sel(md[1], md[0]);
      n_cmp++;
      if ({miso_oe, ready, tx_ready} !== 3'b101) begin
        n_err++;
        $display("FAIL mode%0d_active: oe/ready/tx_ready=%b required 101", md,
                 {miso_oe, ready, tx_ready});
      end
      xfer(8'h3C, 8, md[1], md[0], 1'b0, 8'h00, m);
      end_sel();
      n_cmp++;
      if (m !== 8'hA5) begin
        n_err++; $display("FAIL mode%0d_miso: got %h required a5", md, m);
      end
      n_cmp++;
      if (dout !== 8'h3C) begin
        n_err++; $display("FAIL mode%0d_dout: got %h required 3c", md, dout);
      end
      n_cmp++;
      if (done_cnt - base !== 1) begin
        n_err++; $display("FAIL mode%0d_done: got %0d pulses required 1", md, done_cnt - base);
      end
      n_cmp++;
      if ({miso_oe, ready} !== 2'b01) begin
        n_err++; $display("FAIL mode%0d_deselect: oe/ready=%b required 01", md, {miso_oe, ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    int base;
    base = done_cnt;
    write_tx(8'h11);
    begin_sel(1'b0, 1'b0);
    xfer(8'h5A, 8, 1'b0, 1'b0, 1'b1, 8'h22, m1);
    xfer(8'hC3, 8, 1'b0, 1'b0, 1'b0, 8'h00, m2);
    end_sel();
    n_cmp++;
    if (m1 !== 8'h11) begin
      n_err++; $display("FAIL b2b_miso_w1: got %h required 11", m1);
    end
    n_cmp++;
    if (m2 !== 8'h22) begin
      n_err++; $display("FAIL b2b_miso_w2: got %h required 22", m2);
    end
    n_cmp++;
    if (done_cnt - base !== 2) begin
      n_err++; $display("FAIL b2b_done: got %0d pulses required 2", done_cnt - base);
    end
    n_cmp++;
    if (dout_log[base % 8] !== 8'h5A) begin
      n_err++; $display("FAIL b2b_dout_w1: got %h required 5a", dout_log[base % 8]);
    end
    n_cmp++;
    if (dout_log[(base + 1) % 8] !== 8'hC3) begin
      n_err++; $display("FAIL b2b_dout_w2: got %h required c3", dout_log[(base + 1) % 8]);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] m;
    int bd, bu;
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++; $display("FAIL undr_pre_ready: got %b required 1", tx_ready);
    end
    bd = done_cnt;
    bu = undr_cnt;
    begin_sel(1'b0, 1'b1);
    xfer(8'h96, 8, 1'b0, 1'b1, 1'b0, 8'h00, m);
    end_sel();
    n_cmp++;
    if (m !== 8'h00) begin
      n_err++; $display("FAIL undr_miso: got %h required 00", m);
    end
    n_cmp++;
    if (undr_cnt - bu !== 1) begin
      n_err++; $display("FAIL undr_pulses: got %0d required 1", undr_cnt - bu);
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++; $display("FAIL undr_tx_ready: got %b required 1", tx_ready);
    end
    n_cmp++;
    if (dout !== 8'h96 || done_cnt - bd !== 1) begin
      n_err++;
      $display("FAIL undr_rx: dout=%h done=%0d required 96 and 1", dout, done_cnt - bd);
    end
  endtask

  task automatic test_abort();
    logic [7:0] m;
    int base;
    base = done_cnt;
    write_tx(8'h77);
    begin_sel(1'b0, 1'b0);
    xfer(8'hFF, 5, 1'b0, 1'b0, 1'b0, 8'h00, m);
    end_sel();
    n_cmp++;
    if (m[4:0] !== 5'b01110) begin
      n_err++; $display("FAIL abort_miso: got %b required 01110", m[4:0]);
    end
    n_cmp++;
    if (done_cnt - base !== 0) begin
      n_err++; $display("FAIL abort_done: got %0d pulses required 0", done_cnt - base);
    end
    n_cmp++;
    if (dout !== 8'h96) begin
      n_err++; $display("FAIL abort_dout_hold: got %h required 96", dout);
    end
    write_tx(8'h4B);
    begin_sel(1'b0, 1'b0);
    xfer(8'hE1, 8, 1'b0, 1'b0, 1'b0, 8'h00, m);
    end_sel();
    n_cmp++;
    if (dout !== 8'hE1 || done_cnt - base !== 1) begin
      n_err++;
      $display("FAIL abort_next_rx: dout=%h done=%0d required e1 and 1", dout, done_cnt - base);
    end
    n_cmp++;
    if (m !== 8'h4B) begin
      n_err++; $display("FAIL abort_next_miso: got %h required 4b", m);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] m;
    int base;
    write_tx(8'hC5);
    begin_sel(1'b0, 1'b0);
    xfer(8'h0F, 4, 1'b0, 1'b0, 1'b0, 8'h00, m);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    ss_n = 1'b1;
    sclk = 1'b0;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(HP);
    base = done_cnt;
    write_tx(8'h3A);
    begin_sel(1'b0, 1'b0);
    xfer(8'hA7, 8, 1'b0, 1'b0, 1'b0, 8'h00, m);
    end_sel();
    n_cmp++;
    if (dout !== 8'hA7 || done_cnt - base !== 1) begin
      n_err++;
      $display("FAIL midrst_next_rx: dout=%h done=%0d required a7 and 1", dout, done_cnt - base);
    end
    n_cmp++;
    if (m !== 8'h3A) begin
      n_err++; $display("FAIL midrst_next_miso: got %h required 3a", m);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
